axi_sram_wslave: RTL and testbench

AXI write-path slave front end for an SRAM-backed slave (S0/S1). It sits directly downstream of the write-data router and consumes the routed AW and W channels. Each W beat becomes a byte-masked SRAM word write. It returns one B response per burst, stalling new bursts while the slave's read path is busy.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_sram_wslave_if.sv | 42 ++++
 rtl/axi_sram_wslave.sv | 86 ++++++++
 tb/tb_axi_sram_wslave.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI write-path widths, response/burst codes and the write-slave state encoding.
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int IDS_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int LEN_W  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wstate_t;

endpackage

// File: rtl/axi_sram_wslave_if.sv
// AXI AW/W/B channel bundle between the write-data router (master) and an SRAM write slave.
interface axi_sram_wslave_if
  import axi_pkg::*;
#(
  parameter int IDW = IDS_W
);
  logic [IDW-1:0]    AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [IDW-1:0]    BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

endinterface

// File: rtl/axi_sram_wslave.sv
// AXI write slave: one burst at a time, each W beat is a same-cycle byte-masked SRAM write.
// W is always ready in DATA (1 beat/cycle); new AW stalls during a burst, its response, or rd_active.
module axi_sram_wslave
  import axi_pkg::*;
#(
  parameter int IDW = IDS_W,
  parameter int SAW = 14
) (
  input  logic              clk,
  input  logic              rst,
  axi_sram_wslave_if.slave  axi,
  input  logic              rd_active,
  output logic              sram_we,
  output logic [SAW-1:0]    sram_addr,
  output logic [DATA_W-1:0] sram_di,
  output logic [DATA_W-1:0] sram_bweb
);

  wstate_t          state, nxt;
  logic [IDW-1:0]   id;
  logic [SAW-1:0]   addr;
  logic [LEN_W-1:0] len, cnt;
  logic             fixed, err;
  logic             aw_hs, w_hs, in_range;
  logic             unused_bits;

  assign aw_hs    = axi.AWVALID & axi.AWREADY;
  assign w_hs     = axi.WVALID & axi.WREADY;
  assign in_range = (cnt <= len);

  assign unused_bits = ^{axi.AWSIZE, axi.AWADDR[ADDR_W-1:SAW+2], axi.AWADDR[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (aw_hs) nxt = DATA;
      DATA:    if (w_hs && axi.WLAST) nxt = RESP;
      RESP:    if (axi.BREADY) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // AWREADY is gated by rst so it reads 0 for the whole reset interval.
  always_comb begin
    axi.AWREADY = rst && (state == IDLE) && !rd_active;
    axi.WREADY  = (state == DATA);
    axi.BVALID  = (state == RESP);
    axi.BID     = id;
    axi.BRESP   = ((state == RESP) && err) ? RESP_SLVERR : RESP_OKAY;
    sram_we     = w_hs && in_range;
    sram_addr   = addr;
    sram_di     = sram_we ? axi.WDATA : '0;
    sram_bweb   = '1;
    for (int i = 0; i < STRB_W; i++)
      sram_bweb[8*i +: 8] = {8{~(sram_we & axi.WSTRB[i])}};
  end

  // Beats past len are swallowed but flag SLVERR; a short burst also flags it on WLAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id    <= '0;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      fixed <= 1'b0;
      err   <= 1'b0;
    end else if (aw_hs) begin
      id    <= axi.AWID;
      addr  <= axi.AWADDR[SAW+1:2];
      len   <= axi.AWLEN;
      fixed <= (axi.AWBURST == BURST_FIXED);
      cnt   <= '0;
      err   <= 1'b0;
    end else if (w_hs) begin
      if (!in_range || (axi.WLAST && (cnt != len))) err <= 1'b1;
      if (cnt != '1) cnt <= cnt + LEN_W'(1);
      if (!fixed) addr <= addr + SAW'(1);
    end
  end

endmodule

// File: tb/tb_axi_sram_wslave.sv
// Directed bench for axi_sram_wslave: inputs driven 1 time unit after posedge, outputs sampled before the next edge.
module tb_axi_sram_wslave;
  import axi_pkg::*;

  logic        clk;
  logic        rst;
  logic        rd_active;
  logic        sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_di;
  logic [31:0] sram_bweb;

  int n_chk  = 0;
  int n_fail = 0;

  axi_sram_wslave_if #(.IDW(8)) axi ();

  axi_sram_wslave #(.IDW(8), .SAW(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .rd_active (rd_active),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_di   (sram_di),
    .sram_bweb (sram_bweb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents AW, expects it to be accepted at the coming edge, then expects WREADY next cycle.
  task automatic do_aw(input logic [7:0] id, input logic [31:0] a, input logic [3:0] l,
                       input logic [1:0] b);
    axi.AWID = id; axi.AWADDR = a; axi.AWLEN = l; axi.AWBURST = b; axi.AWSIZE = 3'd2;
    axi.AWVALID = 1'b1;
    #1;
    chk("aw_ready", axi.AWREADY, 1'b1);
    tick();
    axi.AWVALID = 1'b0;
    chk("w_ready_after_aw", axi.WREADY, 1'b1);
  endtask

  task automatic do_w(input string tag, input logic [31:0] d, input logic [3:0] s, input logic last,
                      input logic exp_we, input logic [13:0] exp_addr, input logic [31:0] exp_bweb);
    axi.WDATA = d; axi.WSTRB = s; axi.WLAST = last; axi.WVALID = 1'b1;
    #1;
    chk({tag, "_we"}, sram_we, exp_we);
    if (exp_we) begin
      chk({tag, "_addr"}, sram_addr, exp_addr);
      chk({tag, "_di"}, sram_di, d);
    end
    chk({tag, "_bweb"}, sram_bweb, exp_bweb);
    tick();
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;
  endtask

  task automatic chk_b(input string tag, input logic [7:0] id, input logic [1:0] resp);
    chk({tag, "_bvalid"}, axi.BVALID, 1'b1);
    chk({tag, "_bid"}, axi.BID, id);
    chk({tag, "_bresp"}, axi.BRESP, resp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, axi.AWREADY, 1'b0);
    chk({tag, "_wready"}, axi.WREADY, 1'b0);
    chk({tag, "_bvalid"}, axi.BVALID, 1'b0);
    chk({tag, "_bid"}, axi.BID, 8'h00);
    chk({tag, "_bresp"}, axi.BRESP, 2'b00);
    chk({tag, "_we"}, sram_we, 1'b0);
    chk({tag, "_addr"}, sram_addr, 14'h0);
    chk({tag, "_di"}, sram_di, 32'h0);
    chk({tag, "_bweb"}, sram_bweb, 32'hFFFF_FFFF);
  endtask

  initial begin
    rst = 1'b0; rd_active = 1'b0;
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = 3'd2; axi.AWBURST = 2'b01;
    axi.AWVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0;
    axi.BREADY = 1'b1;

    // Reset values, with AWVALID high to show AWREADY stays low in reset
    #2;
    axi.AWVALID = 1'b1;
    #1;
    chk_reset_outputs("reset");
    axi.AWVALID = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // INCR burst of 4 from 0x40
    do_aw(8'h5A, 32'h0000_0040, 4'd3, BURST_INCR);
    do_w("incr_b0", 32'h1, 4'hF, 1'b0, 1'b1, 14'h010, 32'h0);
    do_w("incr_b1", 32'h2, 4'hF, 1'b0, 1'b1, 14'h011, 32'h0);
    do_w("incr_b2", 32'h3, 4'hF, 1'b0, 1'b1, 14'h012, 32'h0);
    do_w("incr_b3", 32'h4, 4'hF, 1'b1, 1'b1, 14'h013, 32'h0);
    chk("incr_wready_low", axi.WREADY, 1'b0);
    chk_b("incr", 8'h5A, RESP_OKAY);
    tick();
    chk("incr_back_idle_awready", axi.AWREADY, 1'b1);
    chk("incr_back_idle_bvalid", axi.BVALID, 1'b0);

    // FIXED burst, partial strobes
    do_aw(8'h21, 32'h0000_0008, 4'd1, BURST_FIXED);
    do_w("fixed_b0", 32'hAABB_CCDD, 4'h5, 1'b0, 1'b1, 14'h002, 32'hFF00_FF00);
    do_w("fixed_b1", 32'h1122_3344, 4'h5, 1'b1, 1'b1, 14'h002, 32'hFF00_FF00);
    chk_b("fixed", 8'h21, RESP_OKAY);
    tick();

    // Early WLAST: AWLEN=1, last on first beat
    do_aw(8'h33, 32'h0000_0100, 4'd1, BURST_INCR);
    do_w("short_b0", 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 14'h040, 32'h0);
    chk_b("short", 8'h33, RESP_SLVERR);
    tick();

    // Overrun: AWLEN=0, two beats, second not written
    do_aw(8'h44, 32'h0000_0200, 4'd0, BURST_INCR);
    do_w("long_b0", 32'h0000_00AA, 4'hF, 1'b0, 1'b1, 14'h080, 32'h0);
    do_w("long_b1", 32'h0000_00BB, 4'hF, 1'b1, 1'b0, 14'h0, 32'hFFFF_FFFF);
    chk_b("long", 8'h44, RESP_SLVERR);
    tick();

    // rd_active blocks AW; release accepts in the same cycle
    rd_active = 1'b1;
    axi.AWID = 8'h66; axi.AWADDR = 32'h0000_0400; axi.AWLEN = 4'd1; axi.AWBURST = BURST_INCR;
    axi.AWVALID = 1'b1;
    #1;
    chk("rdact_awready_0", axi.AWREADY, 1'b0);
    tick();
    chk("rdact_awready_1", axi.AWREADY, 1'b0);
    chk("rdact_no_data", axi.WREADY, 1'b0);
    rd_active = 1'b0;
    do_aw(8'h66, 32'h0000_0400, 4'd1, BURST_INCR);
    rd_active = 1'b1;
    do_w("rdact_b0", 32'h5555_0000, 4'hF, 1'b0, 1'b1, 14'h100, 32'h0);
    do_w("rdact_b1", 32'h5555_0001, 4'h8, 1'b1, 1'b1, 14'h101, 32'h00FF_FFFF);
    chk_b("rdact", 8'h66, RESP_OKAY);
    rd_active = 1'b0;
    tick();

    // BREADY low holds the response; AW refused meanwhile
    axi.BREADY = 1'b0;
    do_aw(8'h77, 32'h0000_0010, 4'd0, BURST_INCR);
    do_w("hold_b0", 32'h7, 4'hF, 1'b1, 1'b1, 14'h004, 32'h0);
    axi.AWID = 8'h99; axi.AWADDR = 32'h0; axi.AWLEN = 4'd0; axi.AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_b("hold", 8'h77, RESP_OKAY);
      chk("hold_awready", axi.AWREADY, 1'b0);
      tick();
    end
    axi.AWVALID = 1'b0;
    axi.BREADY = 1'b1;
    #1;
    chk_b("hold_release", 8'h77, RESP_OKAY);
    tick();
    chk("hold_bvalid_drop", axi.BVALID, 1'b0);

    // Address wrap at the top of the SRAM
    do_aw(8'h88, 32'h0000_FFFC, 4'd1, BURST_INCR);
    do_w("wrap_b0", 32'hCAFE_0000, 4'hF, 1'b0, 1'b1, 14'h3FFF, 32'h0);
    do_w("wrap_b1", 32'hCAFE_0001, 4'hF, 1'b1, 1'b1, 14'h0000, 32'h0);
    chk_b("wrap", 8'h88, RESP_OKAY);
    tick();

    // Reset asserted during beat 2 of a 4-beat burst
    do_aw(8'hAB, 32'h0000_0080, 4'd3, BURST_INCR);
    do_w("rst_b0", 32'h10, 4'hF, 1'b0, 1'b1, 14'h020, 32'h0);
    axi.WDATA = 32'h11; axi.WSTRB = 4'hF; axi.WLAST = 1'b0; axi.WVALID = 1'b1;
    #1;
    chk("rst_b1_we_before", sram_we, 1'b1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    axi.WVALID = 1'b0;
    tick(); tick();
    chk("rst_mid_no_b", axi.BVALID, 1'b0);
    rst = 1'b1;
    tick();
    chk("post_rst_no_b", axi.BVALID, 1'b0);
    do_aw(8'hCD, 32'h0000_0084, 4'd0, BURST_INCR);
    do_w("post_rst_b0", 32'h99, 4'h1, 1'b1, 1'b1, 14'h021, 32'hFFFF_FF00);
    chk_b("post_rst", 8'hCD, RESP_OKAY);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
